window_addr_scheduler: RTL and testbench

//  Parametrised read-address sequencer for line-window filters (Sobel/Canny/NMS stages).

---
 rtl/win_sched_pkg.sv | 32 +++
 rtl/window_addr_scheduler_if.sv | 27 ++
 rtl/win_tag_delay.sv | 36 +++
 rtl/window_addr_scheduler.sv | 141 ++++++++++++++
 tb/tb_window_addr_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/win_sched_pkg.sv
// Shared types and elaboration helpers for the window address scheduler.
// WIN_ADDR_SCHED_CLAMP_EN moves the scan origin to row 0.
package win_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic [2:0] win_idx;
    logic       win_last;
  } win_tag_t;

  function automatic int unsigned origin_row(int unsigned win_rows);
`ifdef WIN_ADDR_SCHED_CLAMP_EN
    return 0;
`else
    return win_rows - 1;
`endif
  endfunction

  function automatic int unsigned origin_base(int unsigned img_w, int unsigned win_rows);
    return origin_row(win_rows) * img_w;
  endfunction

  function automatic int unsigned frame_size(int unsigned img_w, int unsigned img_h);
    return img_w * img_h;
  endfunction

endpackage

// File: rtl/window_addr_scheduler_if.sv
// Read-address / returning-tag bus between the scheduler (master) and its consumer (slave).
interface window_addr_scheduler_if #(
  parameter int unsigned ADDR_W = 20
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [2:0]        win_idx;
  logic              win_last;
  logic [ADDR_W-1:0] col_pos;
  logic [ADDR_W-1:0] row_pos;
  logic              q_valid;
  logic [2:0]        q_win_idx;
  logic              q_win_last;

  modport master (
    output rd_addr, rd_valid, win_idx, win_last, col_pos, row_pos,
    output q_valid, q_win_idx, q_win_last,
    input  rd_ready
  );

  modport slave (
    input  rd_addr, rd_valid, win_idx, win_last, col_pos, row_pos,
    input  q_valid, q_win_idx, q_win_last,
    output rd_ready
  );
endinterface

// File: rtl/win_tag_delay.sv
// Fixed-latency shift register carrying accepted-beat valid and tap tags
// so they line up with RAM read data.
module win_tag_delay
  import win_sched_pkg::*;
#(
  parameter int unsigned Lat = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     valid_i,
  input  win_tag_t tag_i,
  output logic     valid_o,
  output win_tag_t tag_o
);

  logic     [Lat-1:0] valid_q;
  win_tag_t [Lat-1:0] tag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int unsigned i = 1; i < Lat; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Lat-1];
  assign tag_o   = tag_q[Lat-1];

endmodule

// File: rtl/window_addr_scheduler.sv
// Raster read-address sequencer emitting WIN_ROWS vertical taps per pixel.
// Define WIN_ADDR_SCHED_CLAMP_EN to scan from row 0 with the top border replicated.
module window_addr_scheduler
  import win_sched_pkg::*;
#(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned WIN_ROWS = 4,
  parameter int unsigned RAM_LAT  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    abort_i,
  window_addr_scheduler_if.master bus,
  output logic                    busy_o,
  output logic                    frame_done_o
);

  localparam logic [ADDR_W-1:0] BaseInit  = ADDR_W'(origin_base(IMG_W, WIN_ROWS));
  localparam logic [ADDR_W-1:0] RowOrigin = ADDR_W'(origin_row(WIN_ROWS));
  localparam logic [ADDR_W-1:0] RowStep   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LastCol   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LastRow   = ADDR_W'(IMG_H - 1);
  localparam logic [2:0]        LastTap   = 3'(WIN_ROWS - 1);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        tap_q, tap_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;

  logic     running;
  logic     beat;
  logic     last_tap;
  win_tag_t tag_in;
  win_tag_t q_tag;

  assign running  = (state_q == StRun);
  assign beat     = running & bus.rd_ready;
  assign last_tap = (tap_q == LastTap);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    tap_d   = tap_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          base_d  = BaseInit;
          addr_d  = BaseInit;
          tap_d   = '0;
          col_d   = '0;
          row_d   = RowOrigin;
        end
      end
      StRun: begin
        if (beat) begin
          if (last_tap) begin
            if (col_q == LastCol && row_q == LastRow) begin
              state_d = StDone;
            end else begin
              // Raster is contiguous, so the next pixel base is always +1.
              base_d = base_q + 1'b1;
              addr_d = base_q + 1'b1;
              tap_d  = '0;
              if (col_q == LastCol) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end else begin
            tap_d = tap_q + 3'd1;
`ifdef WIN_ADDR_SCHED_CLAMP_EN
            addr_d = (ADDR_W'(tap_d) > row_q) ? col_q : addr_q - RowStep;
`else
            addr_d = addr_q - RowStep;
`endif
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
      addr_q  <= '0;
      tap_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      tap_q   <= tap_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign tag_in.win_idx  = tap_q;
  assign tag_in.win_last = last_tap;

  win_tag_delay #(
    .Lat (RAM_LAT)
  ) u_tag_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (beat),
    .tag_i   (tag_in),
    .valid_o (bus.q_valid),
    .tag_o   (q_tag)
  );

  assign bus.rd_addr    = addr_q;
  assign bus.rd_valid   = running;
  assign bus.win_idx    = tap_q;
  assign bus.win_last   = last_tap;
  assign bus.col_pos    = col_q;
  assign bus.row_pos    = row_q;
  assign bus.q_win_idx  = q_tag.win_idx;
  assign bus.q_win_last = q_tag.win_last;
  assign busy_o         = running;
  assign frame_done_o   = (state_q == StDone);

endmodule

// File: tb/tb_window_addr_scheduler.sv
// Directed bench for window_addr_scheduler on a 4x4 frame, 3 taps, RAM latency 2.
module tb_window_addr_scheduler;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned IMG_W    = 4;
  localparam int unsigned IMG_H    = 4;
  localparam int unsigned WIN_ROWS = 3;
  localparam int unsigned RAM_LAT  = 2;
`ifdef WIN_ADDR_SCHED_CLAMP_EN
  localparam int R0 = 0;
`else
  localparam int R0 = WIN_ROWS - 1;
`endif
  localparam int TOTAL = (IMG_H - R0) * IMG_W * WIN_ROWS;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start, abort, busy, frame_done;

  always #5 clk = ~clk;

  window_addr_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  window_addr_scheduler #(
    .ADDR_W   (ADDR_W),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .WIN_ROWS (WIN_ROWS),
    .RAM_LAT  (RAM_LAT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .bus          (bus),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  bit run_exp, fd_exp;
  int exp_n;
  bit hv_valid [RAM_LAT];
  int hv_idx   [RAM_LAT];
  bit hv_last  [RAM_LAT];
  int addr_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_k(int n);
    return n % WIN_ROWS;
  endfunction
  function automatic int m_col(int n);
    return (n / WIN_ROWS) % IMG_W;
  endfunction
  function automatic int m_row(int n);
    return R0 + (n / WIN_ROWS) / IMG_W;
  endfunction
  function automatic int m_addr(int n);
    int r, k;
    r = m_row(n);
    k = m_k(n);
    return ((r >= k) ? r - k : 0) * IMG_W + m_col(n);
  endfunction

  task automatic clear_model();
    run_exp = 0;
    fd_exp  = 0;
    for (int i = 0; i < RAM_LAT; i++) begin
      hv_valid[i] = 0;
      hv_idx[i]   = 0;
      hv_last[i]  = 0;
    end
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model.
  task automatic cyc(input bit st, input bit ab, input bit rnd);
    bit beat, fd_old;
    @(negedge clk);
    bus.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = st;
    abort = ab;
    chk("rd_valid", bus.rd_valid, run_exp);
    chk("busy", busy, run_exp);
    chk("frame_done", frame_done, fd_exp);
    chk("q_valid", bus.q_valid, hv_valid[RAM_LAT-1]);
    if (hv_valid[RAM_LAT-1]) begin
      chk("q_win_idx", bus.q_win_idx, hv_idx[RAM_LAT-1]);
      chk("q_win_last", bus.q_win_last, hv_last[RAM_LAT-1]);
    end
    if (run_exp) begin
      chk("rd_addr", bus.rd_addr, m_addr(exp_n));
      chk("win_idx", bus.win_idx, m_k(exp_n));
      chk("win_last", bus.win_last, m_k(exp_n) == WIN_ROWS - 1);
      chk("col_pos", bus.col_pos, m_col(exp_n));
      chk("row_pos", bus.row_pos, m_row(exp_n));
    end
    beat = run_exp && bus.rd_ready;
    if (beat) addr_log.push_back(int'(bus.rd_addr));
    for (int i = RAM_LAT - 1; i > 0; i--) begin
      hv_valid[i] = hv_valid[i-1];
      hv_idx[i]   = hv_idx[i-1];
      hv_last[i]  = hv_last[i-1];
    end
    hv_valid[0] = beat;
    hv_idx[0]   = m_k(exp_n);
    hv_last[0]  = (m_k(exp_n) == WIN_ROWS - 1);
    fd_old = fd_exp;
    fd_exp = 0;
    if (ab) begin
      run_exp = 0;
    end else if (beat) begin
      exp_n++;
      if (exp_n == TOTAL) begin
        run_exp = 0;
        fd_exp  = 1;
      end
    end else if (!run_exp && !fd_old && st) begin
      run_exp = 1;
      exp_n   = 0;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #1;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_win_idx", bus.win_idx, 0);
    chk("rst_win_last", bus.win_last, 0);
    chk("rst_col_pos", bus.col_pos, 0);
    chk("rst_row_pos", bus.row_pos, 0);
    chk("rst_q_valid", bus.q_valid, 0);
    chk("rst_q_win_idx", bus.q_win_idx, 0);
    chk("rst_q_win_last", bus.q_win_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_end(input string tag, input bit rnd, input int restart_at);
    int n;
    n = 0;
    while ((run_exp || fd_exp) && n < 400) begin
      cyc(n == restart_at, 1'b0, rnd);
      n++;
    end
    chk(tag, (n < 400), 1);
  endtask

  initial begin
    int tbl_i [15];
    int tbl_a [15];
    tbl_i = '{0, 1, 2, 3, 4, 5, 9, 10, 11, 12, 13, 14, 21, 22, 23};
    tbl_a = '{8, 4, 0, 9, 5, 1, 11, 7, 3, 12, 8, 4, 15, 11, 7};
    start = 1'b0;
    abort = 1'b0;
    bus.rd_ready = 1'b0;
    exp_n = 0;
    clear_model();
    do_reset();
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Full frame, consumer always ready.
    addr_log.delete();
    cyc(1'b1, 1'b0, 1'b0);
    run_to_end("frame1_timeout", 1'b0, -1);
    chk("frame1_beats", addr_log.size(), TOTAL);
`ifndef WIN_ADDR_SCHED_CLAMP_EN
    if (addr_log.size() == TOTAL) begin
      for (int i = 0; i < 15; i++) chk("frame1_addr_tbl", addr_log[tbl_i[i]], tbl_a[i]);
    end
`endif
    repeat (RAM_LAT + 1) cyc(1'b0, 1'b0, 1'b0);

    // Random backpressure, with a stray start mid-frame.
    addr_log.delete();
    cyc(1'b1, 1'b0, 1'b1);
    run_to_end("frame2_timeout", 1'b1, 5);
    chk("frame2_beats", addr_log.size(), TOTAL);
    repeat (RAM_LAT + 1) cyc(1'b0, 1'b0, 1'b0);

    // Abort mid-frame: no frame_done, pipeline drains.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // start and abort together from idle.
    cyc(1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-frame.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Recovery frame after reset.
    cyc(1'b1, 1'b0, 1'b1);
    run_to_end("frame3_timeout", 1'b1, -1);
    repeat (RAM_LAT + 1) cyc(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
